// File: rtl/user_wb_timer_gpio.sv
// User-space Wishbone classic slave: GPIO pad registers plus a reloadable
// 32-bit down-counter timer whose FIRED flag drives irq_o.
module user_wb_timer_gpio #(
    parameter int          IO_W     = 38,
    parameter logic [31:0] ADR_BASE = 32'h3000_0000
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic            wbs_cyc_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    input  logic [IO_W-1:0] io_in,
    output logic [IO_W-1:0] io_out,
    output logic [IO_W-1:0] io_oeb,
    output logic            irq_o
);
    typedef enum logic {IDLE, RUN} timer_state_t;

    timer_state_t    state;
    logic [IO_W-1:0] gpio_out, gpio_oeb, in_meta, in_sync;
    logic [IO_W-1:0] out_merged, oeb_merged;
    logic [2:0]      ctrl, ctrl_merged;
    logic [31:0]     load, load_merged, value, rdata;
    logic            fired, irq;
    logic            hit, hi_half, req, wr;
    logic [2:0]      off;
    logic            wr_out_lo, wr_out_hi, wr_oeb_lo, wr_oeb_hi;
    logic            wr_ctrl, wr_load, w1c;
    logic            start, stop, terminal;
    logic            unused_adr;

    // The window spans 64 bytes so adr[5] can select the alias holding pad bits [IO_W-1:32].
    assign hit       = wbs_adr_i[31:6] == ADR_BASE[31:6];
    assign hi_half   = wbs_adr_i[5];
    assign off       = wbs_adr_i[4:2];
    assign unused_adr = ^wbs_adr_i[1:0];
    assign req       = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign wr        = req & wbs_we_i & hit;
    assign wr_out_lo = wr & ~hi_half & (off == 3'd0);
    assign wr_out_hi = wr &  hi_half & (off == 3'd0);
    assign wr_oeb_lo = wr & ~hi_half & (off == 3'd1);
    assign wr_oeb_hi = wr &  hi_half & (off == 3'd1);
    assign wr_ctrl   = wr & ~hi_half & (off == 3'd3);
    assign wr_load   = wr & ~hi_half & (off == 3'd4);
    assign w1c       = wr & ~hi_half & (off == 3'd6) & wbs_sel_i[0] & wbs_dat_i[0];

    always_comb begin
        out_merged  = gpio_out;
        oeb_merged  = gpio_oeb;
        load_merged = load;
        for (int i = 0; i < IO_W; i++) begin
            if (wbs_sel_i[(i % 32) / 8]) begin
                out_merged[i] = wbs_dat_i[i % 32];
                oeb_merged[i] = wbs_dat_i[i % 32];
            end
        end
        for (int b = 0; b < 4; b++) begin
            if (wbs_sel_i[b]) begin
                load_merged[8*b +: 8] = wbs_dat_i[8*b +: 8];
            end
        end
        ctrl_merged = wbs_sel_i[0] ? wbs_dat_i[2:0] : ctrl;
    end

    assign start    = (state == IDLE) & wr_ctrl & ctrl_merged[0];
    assign stop     = (state == RUN) & wr_ctrl & ~ctrl_merged[0];
    assign terminal = (state == RUN) & ~stop & (value == 32'd0);

    always_comb begin
        rdata = '0;
        if (hit) begin
            if (hi_half) begin
                case (off)
                    3'd0:    rdata = 32'(gpio_out[IO_W-1:32]);
                    3'd1:    rdata = 32'(gpio_oeb[IO_W-1:32]);
                    3'd2:    rdata = 32'(in_sync[IO_W-1:32]);
                    default: rdata = '0;
                endcase
            end else begin
                case (off)
                    3'd0:    rdata = gpio_out[31:0];
                    3'd1:    rdata = gpio_oeb[31:0];
                    3'd2:    rdata = in_sync[31:0];
                    3'd3:    rdata = {29'd0, ctrl};
                    3'd4:    rdata = load;
                    3'd5:    rdata = value;
                    3'd6:    rdata = {31'd0, fired};
                    default: rdata = '0;
                endcase
            end
        end
    end

    // Timer updates follow the bus writes so a one-shot terminal count can clear EN last.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            gpio_out  <= '0;
            gpio_oeb  <= '1;
            in_meta   <= '0;
            in_sync   <= '0;
            ctrl      <= '0;
            load      <= '0;
            value     <= '0;
            fired     <= 1'b0;
            irq       <= 1'b0;
            state     <= IDLE;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= req ? rdata : '0;
            in_meta   <= io_in;
            in_sync   <= in_meta;
            if (wr_out_lo) gpio_out[31:0]      <= out_merged[31:0];
            if (wr_out_hi) gpio_out[IO_W-1:32] <= out_merged[IO_W-1:32];
            if (wr_oeb_lo) gpio_oeb[31:0]      <= oeb_merged[31:0];
            if (wr_oeb_hi) gpio_oeb[IO_W-1:32] <= oeb_merged[IO_W-1:32];
            if (wr_ctrl)   ctrl <= ctrl_merged;
            if (wr_load)   load <= load_merged;
            fired <= (fired & ~w1c) | terminal;
            irq   <= fired & ctrl[2];
            case (state)
                IDLE: begin
                    if (start) begin
                        value <= load;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (value == 32'd0) begin
                        if (ctrl[1]) begin
                            value <= load;
                        end else begin
                            ctrl[0] <= 1'b0;
                            state   <= IDLE;
                        end
                    end else begin
                        value <= value - 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io_out = gpio_out;
    assign io_oeb = gpio_oeb;
    assign irq_o  = irq;
endmodule

// File: tb/tb_user_wb_timer_gpio.sv
// Directed plus randomized bench for user_wb_timer_gpio; expected values come
// from byte-lane arithmetic and timer period formulas kept in the bench.
module tb_user_wb_timer_gpio;
    localparam int          IO_W     = 38;
    localparam logic [63:0] IO_MASK  = (64'd1 << IO_W) - 64'd1;
    localparam logic [31:0] A_OUT    = 32'h3000_0000;
    localparam logic [31:0] A_OEB    = 32'h3000_0004;
    localparam logic [31:0] A_IN     = 32'h3000_0008;
    localparam logic [31:0] A_CTRL   = 32'h3000_000C;
    localparam logic [31:0] A_LOAD   = 32'h3000_0010;
    localparam logic [31:0] A_VALUE  = 32'h3000_0014;
    localparam logic [31:0] A_STATUS = 32'h3000_0018;
    localparam logic [31:0] A_RSVD   = 32'h3000_001C;
    localparam logic [31:0] A_HI     = 32'h0000_0020;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]      sel = '0;
    logic [31:0]     adr = '0, wdat = '0;
    logic            ack;
    logic [31:0]     rdat;
    logic [IO_W-1:0] io_in = '0;
    logic [IO_W-1:0] io_out, io_oeb;
    logic            irq;

    int          n_assert = 0;
    int          n_fail = 0;
    int          cyc_cnt = 0;
    logic [63:0] m_out = '0;
    logic [63:0] m_oeb = IO_MASK;

    user_wb_timer_gpio #(.IO_W(IO_W), .ADR_BASE(32'h3000_0000)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_oeb    (io_oeb),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One classic cycle: ack must appear at the first edge and last exactly one cycle.
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd, output int t_ack);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        @(posedge clk); #1;
        t_ack = cyc_cnt;
        check_output("ack_latency", 64'(ack), 64'd1);
        rd = rdat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        check_output("ack_pulse", 64'(ack), 64'd0);
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output int t);
        logic [31:0] dummy;
        wb_xfer(1'b1, a, d, s, dummy, t);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] rd, output int t);
        wb_xfer(1'b0, a, 32'd0, 4'hF, rd, t);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_until(input int c);
        while (cyc_cnt < c) begin @(posedge clk); #1; end
    endtask

    task automatic poll_irq(input int limit, output int t);
        t = -1;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk); #1;
            if (irq === 1'b1) begin
                t = cyc_cnt;
                break;
            end
        end
    endtask

    function automatic logic [63:0] merge_half(input logic [63:0] cur, input logic hi,
                                               input logic [31:0] d, input logic [3:0] s);
        logic [31:0] word;
        logic [63:0] res;
        res  = cur;
        word = hi ? cur[63:32] : cur[31:0];
        for (int b = 0; b < 4; b++) if (s[b]) word[8*b +: 8] = d[8*b +: 8];
        if (hi) res[63:32] = word; else res[31:0] = word;
        return res & IO_MASK;
    endfunction

    initial begin
        logic [31:0] rd, d, a;
        logic [3:0]  s;
        logic        hi, pick_oeb, exp_irq;
        logic [63:0] r_in;
        int          t, t0, tw, tr, tgt, L, fn;

        #1 rst_n = 1'b0;
        #19;
        check_output("reset_ack", 64'(ack), 64'd0);
        check_output("reset_dat", 64'(rdat), 64'd0);
        check_output("reset_io_out", 64'(io_out), 64'd0);
        check_output("reset_io_oeb", 64'(io_oeb), IO_MASK);
        check_output("reset_irq", 64'(irq), 64'd0);
        #2 rst_n = 1'b1;
        wait_cycles(2);

        wb_read(A_OEB + A_HI, rd, t);
        check_output("reset_oeb_hi", 64'(rd), 64'h3F);

        wb_write(A_OUT, 32'hA5A5_A5A5, 4'b0011, t);
        m_out = merge_half(m_out, 1'b0, 32'hA5A5_A5A5, 4'b0011);
        wb_read(A_OUT, rd, t);
        check_output("out_sel0011_read", 64'(rd), 64'h0000_A5A5);
        check_output("out_sel0011_pads", 64'(io_out[15:0]), 64'hA5A5);

        for (int k = 0; k < 16; k++) begin
            pick_oeb = 1'($urandom_range(0, 1));
            hi = 1'($urandom_range(0, 1));
            s = 4'($urandom);
            d = $urandom;
            a = (pick_oeb ? A_OEB : A_OUT) + (hi ? A_HI : 32'd0);
            wb_write(a, d, s, t);
            if (pick_oeb) m_oeb = merge_half(m_oeb, hi, d, s);
            else          m_out = merge_half(m_out, hi, d, s);
            check_output("gpio_io_out", 64'(io_out), m_out);
            check_output("gpio_io_oeb", 64'(io_oeb), m_oeb);
            wb_read(a, rd, t);
            check_output("gpio_readback", 64'(rd),
                         pick_oeb ? (hi ? 64'(m_oeb[63:32]) : 64'(m_oeb[31:0]))
                                  : (hi ? 64'(m_out[63:32]) : 64'(m_out[31:0])));
        end

        r_in = {$urandom, $urandom};
        r_in = r_in & IO_MASK;
        r_in[3:0] = 4'b1010;
        io_in = r_in[IO_W-1:0];
        wait_cycles(3);
        wb_read(A_IN, rd, t);
        check_output("in_lo", 64'(rd), 64'(r_in[31:0]));
        check_output("in_pattern_1010", 64'(rd[3:0]), 64'hA);
        wb_read(A_IN + A_HI, rd, t);
        check_output("in_hi", 64'(rd), 64'(r_in[63:32]));
        wb_read(A_RSVD, rd, t);
        check_output("reserved_reads_0", 64'(rd), 64'd0);
        wb_read(A_CTRL + A_HI, rd, t);
        check_output("alias_unused_reads_0", 64'(rd), 64'd0);
        wb_write(32'h3000_0040, 32'hFFFF_FFFF, 4'hF, t);
        wb_read(A_OUT, rd, t);
        check_output("outside_write_ignored", 64'(rd), 64'(m_out[31:0]));
        wb_read(32'h3000_0040, rd, t);
        check_output("outside_reads_0", 64'(rd), 64'd0);

        // Periodic LOAD=4: fire edges sit at t0 + 5m; irq trails by one cycle.
        wb_write(A_LOAD, 32'd4, 4'hF, t);
        wb_write(A_CTRL, 32'd7, 4'hF, t0);
        poll_irq(50, t);
        check_output("periodic_first_irq", 64'(t), 64'(t0 + 6));
        wb_read(A_VALUE, rd, tr);
        check_output("periodic_value", 64'(rd), 64'(4 - ((tr - 1 - t0) % 5)));
        tgt = t0 + ((cyc_cnt - t0) / 5 + 1) * 5;
        wait_until(tgt - 1);
        wb_write(A_STATUS, 32'd1, 4'h1, tw);
        check_output("w1c_on_terminal_edge", 64'(tw), 64'(tgt));
        check_output("w1c_set_wins_irq", 64'(irq), 64'd1);
        wb_read(A_STATUS, rd, t);
        check_output("w1c_set_wins_status", 64'(rd), 64'd1);
        wb_write(A_CTRL, 32'd0, 4'hF, t);

        for (int k = 0; k < 4; k++) begin
            wb_write(A_STATUS, 32'd1, 4'h1, t);
            L = $urandom_range(1, 9);
            wb_write(A_LOAD, 32'(L), 4'hF, t);
            wb_write(A_CTRL, 32'd7, 4'hF, t0);
            poll_irq(100, t);
            check_output("rand_first_irq", 64'(t), 64'(t0 + L + 2));
            wait_cycles($urandom_range(0, L));
            wb_read(A_VALUE, rd, tr);
            check_output("rand_value", 64'(rd), 64'(L - ((tr - 1 - t0) % (L + 1))));
            wait_cycles($urandom_range(0, L));
            wb_write(A_STATUS, 32'd1, 4'h1, tw);
            exp_irq = ((tw - t0) % (L + 1)) == 0;
            check_output("rand_w1c_irq", 64'(irq), 64'(exp_irq));
            if (!exp_irq) begin
                fn = t0 + ((tw - t0) / (L + 1) + 1) * (L + 1);
                poll_irq(100, t);
                check_output("rand_next_irq", 64'(t), 64'(fn + 1));
            end
            wb_write(A_CTRL, 32'd0, 4'hF, t);
        end

        wb_write(A_STATUS, 32'd1, 4'h1, t);
        wb_write(A_LOAD, 32'd2, 4'hF, t);
        wb_write(A_CTRL, 32'd5, 4'hF, t0);
        poll_irq(50, t);
        check_output("oneshot_irq", 64'(t), 64'(t0 + 4));
        wb_read(A_CTRL, rd, t);
        check_output("oneshot_en_cleared", 64'(rd), 64'd4);
        wb_read(A_VALUE, rd, t);
        check_output("oneshot_value_0", 64'(rd), 64'd0);
        wb_read(A_STATUS, rd, t);
        check_output("oneshot_fired", 64'(rd), 64'd1);
        wb_write(A_STATUS, 32'd1, 4'h1, t);
        check_output("oneshot_w1c_irq", 64'(irq), 64'd0);
        wait_cycles(10);
        check_output("oneshot_no_refire", 64'(irq), 64'd0);

        wb_write(A_LOAD, 32'd100, 4'hF, t);
        wb_write(A_CTRL, 32'd1, 4'hF, t0);
        wait_cycles(7);
        wb_write(A_CTRL, 32'd0, 4'hF, tw);
        wb_read(A_VALUE, rd, t);
        check_output("stop_value_frozen", 64'(rd), 64'(100 - (tw - 1 - t0)));
        wait_cycles(5);
        wb_read(A_VALUE, rd, t);
        check_output("stop_value_still", 64'(rd), 64'(100 - (tw - 1 - t0)));

        wb_write(A_LOAD, 32'd0, 4'hF, t);
        wb_write(A_CTRL, 32'd7, 4'hF, t0);
        wait_cycles(3);
        wb_write(A_STATUS, 32'd1, 4'h1, t);
        check_output("load0_fires_every_cycle", 64'(irq), 64'd1);
        wb_read(A_VALUE, rd, t);
        check_output("load0_value", 64'(rd), 64'd0);
        wb_write(A_CTRL, 32'd0, 4'hF, t);

        wb_write(A_OUT, 32'h1234_5678, 4'hF, t);
        wb_write(A_STATUS, 32'd1, 4'h1, t);
        wb_write(A_LOAD, 32'd30, 4'hF, t);
        wb_write(A_CTRL, 32'd7, 4'hF, t0);
        wait_cycles(5);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_VALUE; sel = 4'hF;
        @(posedge clk); #1;
        check_output("ack_before_reset", 64'(ack), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_output("midreset_ack", 64'(ack), 64'd0);
        check_output("midreset_dat", 64'(rdat), 64'd0);
        check_output("midreset_io_out", 64'(io_out), 64'd0);
        check_output("midreset_io_oeb", 64'(io_oeb), IO_MASK);
        check_output("midreset_irq", 64'(irq), 64'd0);
        cyc = 1'b0; stb = 1'b0;
        #2 rst_n = 1'b1;
        wait_cycles(40);
        check_output("post_reset_no_irq", 64'(irq), 64'd0);
        wb_read(A_CTRL, rd, t);
        check_output("post_reset_ctrl", 64'(rd), 64'd0);
        wb_read(A_VALUE, rd, t);
        check_output("post_reset_value", 64'(rd), 64'd0);
        wb_read(A_STATUS, rd, t);
        check_output("post_reset_status", 64'(rd), 64'd0);
        wb_read(A_OEB, rd, t);
        check_output("post_reset_oeb", 64'(rd), 64'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
